alu_ctrl_pipe: RTL and testbench

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

---
 rtl/alu_ctrl_pipe.sv | 174 +++++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_pipe.sv
// Single-cycle pipelined ALU control decoder with a multi-cycle multiply occupancy FSM.
// Optional macro ALU_CTRL_ILLEGAL_TRAP_EN adds a registered 'illegal' output for undecodable instructions.
module alu_ctrl_pipe #(
   parameter int AW      = 4,
   parameter int MUL_LAT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [5:0]    opcode,
   input  logic [5:0]    funct,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          stall,
   input  logic          flush,
   output logic          reg_dst,
   output logic          alu_src,
   output logic          reg_write,
   output logic          mem_read,
   output logic          mem_write,
   output logic          mem_to_reg,
   output logic          branch,
   output logic          branch_ne,
   output logic          jump,
   output logic [AW-1:0] alu_op,
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   output logic          illegal,
`endif
   output logic          out_valid,
   output logic          mul_busy
);

   typedef enum logic {IDLE, MUL} state_t;

   state_t     state, state_next;
   logic [3:0] count, count_next;

   logic       dec_reg_dst, dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
   logic       dec_mem_to_reg, dec_branch, dec_branch_ne, dec_jump, dec_mult;
   logic [3:0] dec_op;
   logic       accept;

   assign mul_busy = (state == MUL);
   assign in_ready = !mul_busy && !(out_valid && stall);
   assign accept   = in_valid && in_ready && !flush;

   // Unlisted opcodes and R-type functs fall through with every control at zero.
   always_comb begin
      dec_reg_dst    = 1'b0;
      dec_alu_src    = 1'b0;
      dec_reg_write  = 1'b0;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_branch     = 1'b0;
      dec_branch_ne  = 1'b0;
      dec_jump       = 1'b0;
      dec_mult       = 1'b0;
      dec_op         = 4'b0000;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b100000: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0000; end
               6'b100010: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0001; end
               6'b100100: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0010; end
               6'b100101: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0011; end
               6'b101010: begin dec_reg_dst = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0111; end
               6'b011000: begin
                  dec_reg_dst   = 1'b1;
                  dec_reg_write = 1'b1;
                  dec_op        = 4'b1000;
                  dec_mult      = 1'b1;
               end
               default: ;
            endcase
         end
         6'b001000: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0000; end
         6'b001100: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0010; end
         6'b001101: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0011; end
         6'b001010: begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; dec_op = 4'b0111; end
         6'b100011: begin
            dec_alu_src    = 1'b1;
            dec_mem_read   = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_reg_write  = 1'b1;
         end
         6'b101011: begin dec_alu_src = 1'b1; dec_mem_write = 1'b1; end
         6'b000100: begin dec_branch = 1'b1; dec_op = 4'b0001; end
         6'b000101: begin dec_branch = 1'b1; dec_branch_ne = 1'b1; dec_op = 4'b0001; end
         6'b000010: dec_jump = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Counter is loaded with MUL_LAT on acceptance so mul_busy spans exactly MUL_LAT cycles.
   always_comb begin
      state_next = state;
      count_next = count;
      if (flush) begin
         state_next = IDLE;
         count_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && dec_mult) begin
                  state_next = MUL;
                  count_next = 4'(MUL_LAT);
               end
            end
            MUL: begin
               if (count <= 4'd1) begin
                  state_next = IDLE;
                  count_next = '0;
               end else begin
                  count_next = count - 4'd1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   // Every legal instruction writes a register, writes memory, branches or jumps.
   logic dec_illegal;
   assign dec_illegal = !(dec_reg_write || dec_mem_write || dec_branch || dec_jump);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         reg_dst    <= 1'b0;
         alu_src    <= 1'b0;
         reg_write  <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_to_reg <= 1'b0;
         branch     <= 1'b0;
         branch_ne  <= 1'b0;
         jump       <= 1'b0;
         alu_op     <= '0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
         illegal    <= 1'b0;
`endif
         out_valid  <= 1'b0;
      end else if (accept) begin
         reg_dst    <= dec_reg_dst;
         alu_src    <= dec_alu_src;
         reg_write  <= dec_reg_write;
         mem_read   <= dec_mem_read;
         mem_write  <= dec_mem_write;
         mem_to_reg <= dec_mem_to_reg;
         branch     <= dec_branch;
         branch_ne  <= dec_branch_ne;
         jump       <= dec_jump;
         alu_op     <= AW'(dec_op);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
         illegal    <= dec_illegal;
`endif
         out_valid  <= 1'b1;
      end else if (!(stall && out_valid)) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe: a driver pushes expected bundles from a mnemonic-level
// reference decode; a monitor pops them whenever the DUT completes a handshake.
module tb_alu_ctrl_pipe;

   localparam int AW      = 5;
   localparam int MUL_LAT = 4;
   localparam int BW      = AW + 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [5:0]    opcode = '0;
   logic [5:0]    funct = '0;
   logic          in_valid = 1'b0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          in_ready;
   logic          reg_dst, alu_src, reg_write, mem_read, mem_write, mem_to_reg;
   logic          branch, branch_ne, jump, out_valid, mul_busy;
   logic [AW-1:0] alu_op;
   logic          illegal_w;

   int            n_checks = 0;
   int            n_pass   = 0;

   logic [BW-1:0] exp_q[$];
   int            busy_left = 0;
   bit            m_valid   = 1'b0;
   bit            mon_valid = 1'b0;
   logic [BW-1:0] mon_bundle = '0;

   always #5 clk = ~clk;

   alu_ctrl_pipe #(.AW(AW), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .in_valid(in_valid), .in_ready(in_ready), .stall(stall), .flush(flush),
      .reg_dst(reg_dst), .alu_src(alu_src), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .branch(branch), .branch_ne(branch_ne), .jump(jump), .alu_op(alu_op),
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      .illegal(illegal_w),
`endif
      .out_valid(out_valid), .mul_busy(mul_busy)
   );

`ifndef ALU_CTRL_ILLEGAL_TRAP_EN
   assign illegal_w = 1'b0;
`endif

   function automatic logic [BW-1:0] dut_bundle();
      return {illegal_w, reg_dst, alu_src, reg_write, mem_read, mem_write,
              mem_to_reg, branch, branch_ne, jump, alu_op};
   endfunction

   // Reference decode written per instruction mnemonic.
   function automatic logic [BW-1:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
      bit rd = 0, as = 0, rw = 0, mr = 0, mw = 0, mtr = 0, br = 0, bn = 0, jmp = 0, ill = 1;
      logic [AW-1:0] code = '0;
      if (op == 6'h00) begin
         case (fn)
            6'h20: begin rd = 1; rw = 1; code[3:0] = 4'd0; ill = 0; end
            6'h22: begin rd = 1; rw = 1; code[3:0] = 4'd1; ill = 0; end
            6'h24: begin rd = 1; rw = 1; code[3:0] = 4'd2; ill = 0; end
            6'h25: begin rd = 1; rw = 1; code[3:0] = 4'd3; ill = 0; end
            6'h2A: begin rd = 1; rw = 1; code[3:0] = 4'd7; ill = 0; end
            6'h18: begin rd = 1; rw = 1; code[3:0] = 4'd8; ill = 0; end
            default: ;
         endcase
      end else begin
         case (op)
            6'h08: begin as = 1; rw = 1; code[3:0] = 4'd0; ill = 0; end
            6'h0C: begin as = 1; rw = 1; code[3:0] = 4'd2; ill = 0; end
            6'h0D: begin as = 1; rw = 1; code[3:0] = 4'd3; ill = 0; end
            6'h0A: begin as = 1; rw = 1; code[3:0] = 4'd7; ill = 0; end
            6'h23: begin as = 1; mr = 1; mtr = 1; rw = 1; ill = 0; end
            6'h2B: begin as = 1; mw = 1; ill = 0; end
            6'h04: begin br = 1; code[3:0] = 4'd1; ill = 0; end
            6'h05: begin br = 1; bn = 1; code[3:0] = 4'd1; ill = 0; end
            6'h02: begin jmp = 1; ill = 0; end
            default: ;
         endcase
      end
`ifndef ALU_CTRL_ILLEGAL_TRAP_EN
      ill = 0;
`endif
      return {ill, rd, as, rw, mr, mw, mtr, br, bn, jmp, code};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic applyStimulus(input bit v, input logic [5:0] op, input logic [5:0] fn,
                                input bit st, input bit fl);
      bit exp_ready, acc;
      @(negedge clk);
      in_valid = v; opcode = op; funct = fn; stall = st; flush = fl;
      #1;
      exp_ready = (busy_left == 0) && !(m_valid && st);
      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("mul_busy", mul_busy, busy_left > 0);
      acc = v && exp_ready && !fl;
      if (acc) exp_q.push_back(ref_decode(op, fn));
      @(posedge clk);
      if (fl) begin
         m_valid = 0;
         busy_left = 0;
      end else begin
         if (busy_left > 0) busy_left--;
         else if (acc && op == 6'h00 && fn == 6'h18) busy_left = MUL_LAT;
         m_valid = acc ? 1'b1 : (st && m_valid);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1; in_valid = 0; stall = 0; flush = 0;
      #1;
      checkOutput("reset_outputs", {out_valid, mul_busy, dut_bundle()}, '0);
      checkOutput("reset_in_ready", in_ready, 1);
      exp_q.delete();
      busy_left = 0;
      m_valid = 0;
      @(posedge clk);
      #2 rst = 0;
   endtask

   // Monitor: pops the scoreboard on every handshake and tracks hold/clear behaviour.
   initial begin
      bit hs, fl, st;
      forever begin
         @(posedge clk);
         if (rst) begin
            mon_valid = 0;
            mon_bundle = '0;
         end else begin
            hs = in_valid && in_ready && !flush;
            fl = flush;
            st = stall;
            #1;
            if (fl) begin
               mon_valid = 0;
               mon_bundle = '0;
            end else if (hs) begin
               if (exp_q.size() == 0) checkOutput("scoreboard_underflow", exp_q.size(), 1);
               else begin
                  mon_bundle = exp_q.pop_front();
                  mon_valid = 1;
               end
            end else if (!(st && mon_valid)) begin
               mon_valid = 0;
            end
            checkOutput("out_valid", out_valid, mon_valid);
            checkOutput("bundle", dut_bundle(), mon_bundle);
         end
      end
   end

   initial begin
      logic [5:0] ops[10];
      logic [5:0] fns[6];
      logic [5:0] op, fn;
      ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18};

      doReset();
      applyStimulus(1, 6'h00, 6'h22, 0, 0);              // sub
      applyStimulus(1, 6'h23, 6'h00, 0, 0);              // lw
      applyStimulus(1, 6'h2B, 6'h00, 0, 0);              // sw
      applyStimulus(1, 6'h00, 6'h18, 0, 0);              // mult
      repeat (5) applyStimulus(1, 6'h08, 6'h00, 0, 0);   // addi blocked then accepted
      applyStimulus(1, 6'h0A, 6'h00, 0, 0);              // slti
      repeat (3) applyStimulus(1, 6'h0C, 6'h00, 1, 0);   // held by stall
      applyStimulus(1, 6'h0C, 6'h00, 0, 0);
      applyStimulus(1, 6'h00, 6'h18, 0, 0);              // mult then flush
      applyStimulus(0, 6'h00, 6'h00, 0, 0);
      applyStimulus(1, 6'h0D, 6'h00, 0, 1);
      applyStimulus(1, 6'h0D, 6'h00, 0, 0);
      applyStimulus(1, 6'h3F, 6'h00, 0, 0);              // illegal opcode
      applyStimulus(1, 6'h00, 6'h3F, 0, 0);              // illegal funct
      applyStimulus(1, 6'h00, 6'h18, 0, 0);              // mult then reset
      applyStimulus(0, 6'h00, 6'h00, 0, 0);
      doReset();

      for (int i = 0; i < 800; i++) begin
         op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 9)] : 6'($urandom);
         fn = ($urandom_range(0, 7) < 6) ? fns[$urandom_range(0, 5)] : 6'($urandom);
         if ($urandom_range(0, 149) == 0) doReset();
         else applyStimulus($urandom_range(0, 3) != 0, op, fn,
                            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      end

      repeat (3) applyStimulus(0, 6'h00, 6'h00, 0, 0);
      checkOutput("scoreboard_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
